// File: rtl/chess_clock_pkg.sv
// Shared encodings and helpers for the two-player chess clock.
package chess_clock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_RUN_WHITE = 3'd1;
    localparam state_t ST_RUN_BLACK = 3'd2;
    localparam state_t ST_PAUSED    = 3'd3;
    localparam state_t ST_TIMEOUT   = 3'd4;

    localparam logic PLAYER_WHITE = 1'b0;
    localparam logic PLAYER_BLACK = 1'b1;

    function automatic int unsigned max_secs(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned sat_add(
        input int unsigned a,
        input int unsigned b,
        input int unsigned lim
    );
        int unsigned s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/chess_clock_if.sv
// Move/control pulses in, clock face state out.
interface chess_clock_if #(
    parameter int TIME_W = 10
);
    logic              start;
    logic              pause;
    logic              move_done_white;
    logic              move_done_black;
    logic [TIME_W-1:0] white_secs;
    logic [TIME_W-1:0] black_secs;
    logic              white_run;
    logic              black_run;
    logic              to_move;
    logic              timeout;
    logic              loser;

    modport master (
        output start, pause, move_done_white, move_done_black,
        input  white_secs, black_secs, white_run, black_run,
        input  to_move, timeout, loser
    );

    modport slave (
        input  start, pause, move_done_white, move_done_black,
        output white_secs, black_secs, white_run, black_run,
        output to_move, timeout, loser
    );
endinterface

// File: rtl/chess_clock_controller_seconds_tick_gen.sv
// Prescaler that strobes tick for one cycle every CLOCK_HZ enabled cycles.
module seconds_tick_gen #(
    parameter int CLOCK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/chess_clock_controller.sv
// Turn sequencer: owns both players' time, switches the running side,
// applies Fischer increment and detects flag fall.
module chess_clock_controller
    import chess_clock_pkg::*;
#(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int MINUTES   = 5,
    parameter int SECONDS   = 0,
    parameter int INCREMENT = 0,
    parameter int TIME_W    = 10
) (
    input logic          clock,
    input logic          reset,
    chess_clock_if.slave bus
);
    localparam int unsigned MAX      = max_secs(TIME_W);
    localparam int unsigned INIT_RAW = MINUTES * 60 + SECONDS;
    localparam int unsigned INC      = INCREMENT;
    localparam logic [TIME_W-1:0] INIT =
        TIME_W'((INIT_RAW > MAX) ? MAX : INIT_RAW);

    state_t            state;
    state_t            nxt_state;
    logic [TIME_W-1:0] wsecs;
    logic [TIME_W-1:0] bsecs;
    logic [TIME_W-1:0] nxt_w;
    logic [TIME_W-1:0] nxt_b;
    logic              to_move;
    logic              nxt_to_move;
    logic              loser;
    logic              nxt_loser;
    logic              white_run;
    logic              black_run;
    logic              timeout;

    logic              tick;
    logic              clr;
    logic              run;
    logic              active;
    logic              mv;
    logic              flag;
    logic [TIME_W-1:0] cur;
    logic [TIME_W-1:0] dec;
    logic [TIME_W-1:0] upd;
    logic [TIME_W-1:0] nxt_cur;

    seconds_tick_gen #(
        .CLOCK_HZ(CLOCK_HZ)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .en   (run),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        run    = (state == ST_RUN_WHITE) || (state == ST_RUN_BLACK);
        active = (state == ST_RUN_BLACK);
        mv     = active ? bus.move_done_black : bus.move_done_white;
        cur    = active ? bsecs : wsecs;
        dec    = (tick && cur != '0) ? cur - 1'b1 : cur;
        flag   = tick && (dec == '0);
        upd    = TIME_W'(sat_add(32'(dec), INC, MAX));
        // A flag fall swallows the move: no increment, no turn switch.
        nxt_cur = (mv && !flag) ? upd : dec;
    end

    always_comb begin
        nxt_state   = state;
        nxt_w       = wsecs;
        nxt_b       = bsecs;
        nxt_to_move = to_move;
        nxt_loser   = loser;
        clr         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    nxt_state   = ST_RUN_WHITE;
                    nxt_to_move = PLAYER_WHITE;
                    clr         = 1'b1;
                end
            end
            ST_RUN_WHITE, ST_RUN_BLACK: begin
                if (active) begin
                    nxt_b = nxt_cur;
                end else begin
                    nxt_w = nxt_cur;
                end
                if (flag) begin
                    nxt_state = ST_TIMEOUT;
                    nxt_loser = active;
                end else begin
                    if (mv) begin
                        nxt_to_move = ~active;
                        clr         = 1'b1;
                        nxt_state   = active ? ST_RUN_WHITE
                                             : ST_RUN_BLACK;
                    end
                    if (bus.pause) begin
                        nxt_state = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (bus.pause) begin
                    nxt_state = (to_move == PLAYER_BLACK) ? ST_RUN_BLACK
                                                          : ST_RUN_WHITE;
                end
            end
            ST_TIMEOUT: begin
                nxt_state = ST_TIMEOUT;
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            wsecs     <= INIT;
            bsecs     <= INIT;
            to_move   <= PLAYER_WHITE;
            loser     <= PLAYER_WHITE;
            white_run <= 1'b0;
            black_run <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= nxt_state;
            wsecs     <= nxt_w;
            bsecs     <= nxt_b;
            to_move   <= nxt_to_move;
            loser     <= nxt_loser;
            white_run <= (nxt_state == ST_RUN_WHITE);
            black_run <= (nxt_state == ST_RUN_BLACK);
            timeout   <= (nxt_state == ST_TIMEOUT);
        end
    end

    assign bus.white_secs = wsecs;
    assign bus.black_secs = bsecs;
    assign bus.white_run  = white_run;
    assign bus.black_run  = black_run;
    assign bus.to_move    = to_move;
    assign bus.timeout    = timeout;
    assign bus.loser      = loser;
endmodule
